alu_cc_unit: RTL
================

Name: alu_cc_unit

Overview:
- Registered, parametrised Y86-64 execute-stage ALU with a condition-code register.
- Generalises the 64-bit bitwise AND block to four operations (ADD, SUB, AND, XOR) at any data width.
- Adds a one-deep valid/ready output stage and a persistent ZF/SF/OF register.
- Sits between decode (valA/valB) and memory/write-back in the sequential processor.

Parameters:
WIDTH, 64, operand/result width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat offered
in_ready  output  1  unit can accept a beat this cycle
alu_fun  input  2  0=ADD, 1=SUB, 2=AND, 3=XOR
a  input  WIDTH  valA operand
b  input  WIDTH  valB operand
set_cc  input  1  update CC with this beat's flags
out_valid  output  1  result register holds a beat
out_ready  input  1  downstream accepts result
result  output  WIDTH  registered valE
cc  output  3  {ZF,SF,OF}, current CC register

Behaviour:
- Reset is asynchronous: rst=1 immediately forces out_valid=0, result=0 and cc=3'b100 (ZF=1, SF=0, OF=0, matching Y86 initial state). Any in-flight beat is discarded.
- Operations: ADD r=b+a; SUB r=b-a; AND r=b&a; XOR r=b^a. All are modulo 2^WIDTH; carry is dropped.
- Flags: ZF=(r==0), SF=r[WIDTH-1].
- OF for ADD: a and b have the same sign and r's sign differs from it.
- OF for SUB: b and a have different signs and r's sign differs from b's.
- OF=0 for AND and XOR.
- Handshake:
  - accept = in_valid & in_ready.
  - in_ready = ~out_valid | out_ready (combinational pass-through; no bubble under full throughput).
  - Latency is 1 cycle: a beat accepted at edge N makes result/out_valid visible after edge N.
- Output register:
  - Loads only on accept.
  - out_valid clears when out_ready=1 and there is no accept in the same cycle.
  - On a simultaneous drain and accept, the register holds the new beat and out_valid stays 1.
  - While out_valid=1 and out_ready=0, result and out_valid are held stable.
- CC register:
  - Written on the same edge as the result, only when accept & set_cc.
  - set_cc=0 or no accept leaves cc unchanged.
  - in_valid without accept has no effect.
- No other state; WIDTH=2 must elaborate and behave per the rules above.

Optional Feature:
ALU_COND_EVAL_EN
- Defined:
  - Adds input cond_fun[2:0] (0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g, 7 reserved→0) and output cnd (1 bit).
  - cnd is registered alongside result and computed from the cc value before this beat's update (Y86 cmov/jXX semantics).
  - le=(SF^OF)|ZF; l=SF^OF; e=ZF; ne=~ZF; ge=~(SF^OF); g=~(SF^OF)&~ZF.
  - Reset value of cnd is 0.
- Undefined: neither port exists and no condition logic is built.

Decomposition:
- Package alu_pkg holds:
  - ALU_ADD/ALU_SUB/ALU_AND/ALU_XOR codes.
  - CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0.
  - CC_RESET=3'b100.
  - COND_* codes.
- Sub-module alu_core_comb: purely combinational WIDTH-parametrised op select plus flag generation.
- alu_cc_unit owns the handshake, output register, CC register and optional cond logic.

Test Plan:
- Reset: drive rst=1 mid-stream with out_valid=1 → out_valid=0, result=0, cc=3'b100 immediately, without waiting for a clock edge.
- ADD overflow: a=64'h1, b=64'h7FFF_FFFF_FFFF_FFFF, set_cc=1 → next cycle result=64'h8000_0000_0000_0000, cc=3'b011.
- SUB equal then AND hold:
  - SUB a=b=64'd5, set_cc=1 → result=0, cc=3'b100.
  - Then AND a=64'hAA55AA55AA55AA55, b=64'h55AA55AA55AA55AA, set_cc=0 → result=0, cc stays 3'b100.
- XOR alternating: a=64'hAAAAAAAAAAAAAAAA, b=64'h5555555555555555, set_cc=1 → result=64'hFFFF_FFFF_FFFF_FFFF, cc=3'b010.
- Backpressure:
  - out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, result and out_valid frozen, cc unchanged.
  - Raise out_ready → held beat drains and the pending beat is accepted on the same edge.
- ALU_COND_EVAL_EN:
  - SUB a=5, b=3 (r=-2, cc=3'b010).
  - Next beat cond_fun=2 (l) → cnd=1.
  - cond_fun=6 (g) → cnd=0.
  - cond_fun=0 → cnd=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, CC layout,
// condition codes and the Y86 condition evaluation helper.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_LE     = 3'd1;
    localparam logic [2:0] COND_L      = 3'd2;
    localparam logic [2:0] COND_E      = 3'd3;
    localparam logic [2:0] COND_NE     = 3'd4;
    localparam logic [2:0] COND_GE     = 3'd5;
    localparam logic [2:0] COND_G      = 3'd6;

    // Y86 cmov/jXX predicate over a CC value; the reserved code yields 0
    function automatic logic cond_eval(input logic [2:0] fun, input logic [2:0] cc);
        logic lt;
        lt = cc[CC_SF] ^ cc[CC_OF];
        case (fun)
            COND_ALWAYS: cond_eval = 1'b1;
            COND_LE:     cond_eval = lt | cc[CC_ZF];
            COND_L:      cond_eval = lt;
            COND_E:      cond_eval = cc[CC_ZF];
            COND_NE:     cond_eval = ~cc[CC_ZF];
            COND_GE:     cond_eval = ~lt;
            COND_G:      cond_eval = ~lt & ~cc[CC_ZF];
            default:     cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core_comb.sv
// Combinational ALU datapath: op select and ZF/SF/OF generation.
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       alu_fun,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic [2:0]       flags
);

    logic sa, sb, sr, of;

    assign sa = a[WIDTH-1];
    assign sb = b[WIDTH-1];
    assign sr = r[WIDTH-1];

    // Operation select (b op a, carry dropped) and overflow detection by sign rules
    always_comb begin
        r  = '0;
        of = 1'b0;
        case (alu_fun)
            ALU_ADD: begin
                r  = b + a;
                of = (sa == sb) && (sr != sa);
            end
            ALU_SUB: begin
                r  = b - a;
                of = (sa != sb) && (sr != sb);
            end
            ALU_AND: r = b & a;
            default: r = b ^ a;
        endcase
    end

    assign flags[CC_ZF] = (r == '0);
    assign flags[CC_SF] = sr;
    assign flags[CC_OF] = of;

endmodule

// File: rtl/alu_cc_unit.sv
// Registered execute-stage ALU with a persistent {ZF,SF,OF} register and a
// one-deep valid/ready output stage.
// Optional macro ALU_COND_EVAL_EN adds cond_fun/cnd, evaluated on the CC
// value held before the current beat's update.
module alu_cc_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_fun,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       cc
`ifdef ALU_COND_EVAL_EN
    ,
    input  logic [2:0]       cond_fun,
    output logic             cnd
`endif
);

    logic             accept;
    logic [WIDTH-1:0] alu_r;
    logic [2:0]       alu_flags;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic [2:0]       cc_d, cc_q;

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .alu_fun (alu_fun),
        .a       (a),
        .b       (b),
        .r       (alu_r),
        .flags   (alu_flags)
    );

    // Output stage frees up in the same cycle it drains, so full throughput has no bubble
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // Next-state for result/valid/CC: load on accept, drop valid on drain-only
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        cc_d        = cc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = alu_r;
            if (set_cc)
                cc_d = alu_flags;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset matches Y86 initial CC and discards any held beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cc_q        <= CC_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cc_q        <= cc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cc        = cc_q;

`ifdef ALU_COND_EVAL_EN
    logic cnd_d, cnd_q;

    // Predicate uses the CC from before this beat, as cmov/jXX expect
    always_comb begin
        cnd_d = cnd_q;
        if (accept)
            cnd_d = cond_eval(cond_fun, cc_q);
    end

    // Condition result travels with the result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnd_q <= 1'b0;
        else
            cnd_q <= cnd_d;
    end

    assign cnd = cnd_q;
`endif

endmodule
